// File: rtl/instr_mem_resp_pkg.sv
// rtl/instr_mem_resp_pkg.sv - shared types and constants for the instruction fetch block
package instr_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int             INSTR_W     = 32;
  localparam logic [31:0]    NOP_INSTR   = 32'h0000_0000;
  localparam int             LATENCY_MIN = 1;
  localparam int             LATENCY_MAX = 15;
  localparam int             CNT_W       = 4;

  // Upper PC bits beyond the word index flag an out-of-range fetch.
  function automatic logic pc_out_of_range(input logic [31:0] pc, input int unsigned addr_w);
    return (pc >> addr_w) != 32'd0;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - word storage, synchronous write port, asynchronous read port
module instr_mem_array
  import instr_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_resp.sv
// rtl/instr_mem_resp.sv - instruction fetch FSM with fixed-latency response
// Defining INSTR_MEM_LAST_HIT_EN adds a one-entry last-fetch bypass register.
module instr_mem_resp
  import instr_mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        PC,
  input  logic               READ,
  output logic               BUSYWAIT,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               INSTR_VALID,
  output logic               ADDR_ERR,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  WADDR,
  input  logic [INSTR_W-1:0] WDATA
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("instr_mem_resp: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [INSTR_W-1:0] rd_data;
  logic               fetch_err;

`ifdef INSTR_MEM_LAST_HIT_EN
  logic               hit_valid_q, hit_valid_d;
  logic [31:0]        hit_tag_q, hit_tag_d;
  logic [INSTR_W-1:0] hit_data_q, hit_data_d;
  logic               hit;

  assign hit = hit_valid_q && (hit_tag_q == PC);
`endif

  // Reset wins over a load write on the same edge.
  instr_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (WRITE & ~RESET),
    .waddr (WADDR),
    .wdata (WDATA),
    .raddr (addr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign fetch_err = pc_out_of_range(addr_q, ADDR_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
`ifdef INSTR_MEM_LAST_HIT_EN
    hit_valid_d = hit_valid_q;
    hit_tag_d   = hit_tag_q;
    hit_data_d  = hit_data_q;
`endif

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (READ) begin
          addr_d  = PC;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = BUSY;
`ifdef INSTR_MEM_LAST_HIT_EN
          if (hit) begin
            instr_d = hit_data_q;
            valid_d = 1'b1;
            err_d   = pc_out_of_range(PC, ADDR_W);
            busy_d  = 1'b0;
            state_d = RESP;
          end
`endif
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          instr_d = fetch_err ? NOP_INSTR : rd_data;
          valid_d = 1'b1;
          err_d   = fetch_err;
          busy_d  = 1'b0;
          state_d = RESP;
`ifdef INSTR_MEM_LAST_HIT_EN
          hit_valid_d = 1'b1;
          hit_tag_d   = addr_q;
          hit_data_d  = fetch_err ? NOP_INSTR : rd_data;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef INSTR_MEM_LAST_HIT_EN
    // Invalidate after the update so a same-edge write never leaves a stale entry.
    if (WRITE && hit_valid_d && (hit_tag_d[ADDR_W-1:0] == WADDR)) begin
      hit_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef INSTR_MEM_LAST_HIT_EN
      hit_valid_q <= 1'b0;
      hit_tag_q   <= '0;
      hit_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef INSTR_MEM_LAST_HIT_EN
      hit_valid_q <= hit_valid_d;
      hit_tag_q   <= hit_tag_d;
      hit_data_q  <= hit_data_d;
`endif
    end
  end

  assign BUSYWAIT    = busy_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;
  assign ADDR_ERR    = err_q;

endmodule
